// File: rtl/axil_pmem_bridge_if.sv
// +-----------------------------------------------------------------------------+
// | axil_pmem_bridge_if : AXI4-Lite slave bus plus ren/wen physical-memory port |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface axil_pmem_bridge_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    // Bridge view: AXI slave towards the core, strobe master towards memory.
    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb,
               bready, mem_rdata,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
               mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb,
               bready, mem_rdata,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
               mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

`default_nettype wire

// File: rtl/axil_pmem_bridge.sv
// +-----------------------------------------------------------------------------+
// | axil_pmem_bridge : serialising AXI4-Lite to single-cycle pmem strobe bridge |
// | with programmable read/write latency. Optional macro: PMEM_ADDR_CHECK_EN    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module axil_pmem_bridge #(
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1,
    parameter logic [31:0] PMEM_BASE = 32'h8000_0000,
    parameter logic [31:0] PMEM_SIZE = 32'h0800_0000
) (
    input  wire logic          clock,
    input  wire logic          reset,
    axil_pmem_bridge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    state_t      state;
    grant_t      last_grant;
    logic [3:0]  lat_cnt;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        acc_ok;

    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        mem_ren_q;
    logic [31:0] mem_raddr_q;
    logic        mem_wen_q;
    logic [31:0] mem_waddr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;

    logic        idle;
    logic        rd_req;
    logic        wr_req;
    logic        rd_win;
    logic        wr_win;
    logic        awready_c;
    logic        wready_c;
    logic [31:0] wr_addr_eff;
    logic [31:0] wr_data_eff;
    logic [3:0]  wr_strb_eff;
    logic        rd_ok;
    logic        wr_ok;

    // Readies are held low while reset is asserted so nothing is accepted.
    assign idle   = (state == IDLE) && !reset;
    assign rd_req = bus.arvalid;
    assign wr_req = (aw_got | bus.awvalid) & (w_got | bus.wvalid);
    assign rd_win = rd_req & (!wr_req | (last_grant == GRANT_WRITE));
    assign wr_win = wr_req & !rd_win;

    assign awready_c = idle & !aw_got & !rd_win;
    assign wready_c  = idle & !w_got & !rd_win;

    assign wr_addr_eff = aw_got ? aw_addr : bus.awaddr;
    assign wr_data_eff = w_got  ? w_data  : bus.wdata;
    assign wr_strb_eff = w_got  ? w_strb  : bus.wstrb;

`ifdef PMEM_ADDR_CHECK_EN
    function automatic logic in_range(input logic [31:0] addr);
        return (addr >= PMEM_BASE) && ((addr - PMEM_BASE) < PMEM_SIZE);
    endfunction

    assign rd_ok = in_range(bus.araddr);
    assign wr_ok = in_range(wr_addr_eff);
`else
    logic [63:0] unused_cfg;

    assign unused_cfg = {PMEM_BASE, PMEM_SIZE};
    assign rd_ok      = 1'b1;
    assign wr_ok      = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GRANT_WRITE;
            lat_cnt     <= 4'd0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_addr     <= 32'd0;
            w_data      <= 32'd0;
            w_strb      <= 4'd0;
            acc_ok      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= 2'b00;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= 32'd0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 4'd0;
        end else begin
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.awvalid && awready_c) begin
                        aw_got  <= 1'b1;
                        aw_addr <= bus.awaddr;
                    end
                    if (bus.wvalid && wready_c) begin
                        w_got  <= 1'b1;
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrb;
                    end

                    // A winning write consumes both halves, overriding the captures above.
                    if (rd_win) begin
                        mem_raddr_q <= bus.araddr;
                        acc_ok      <= rd_ok;
                        lat_cnt     <= RD_LOAD;
                        last_grant  <= GRANT_READ;
                        mem_ren_q   <= (RD_LAT == 1) && rd_ok;
                        state       <= RD_WAIT;
                    end else if (wr_win) begin
                        aw_got      <= 1'b0;
                        w_got       <= 1'b0;
                        mem_waddr_q <= wr_addr_eff;
                        mem_wdata_q <= wr_data_eff;
                        mem_wmask_q <= wr_strb_eff;
                        acc_ok      <= wr_ok;
                        lat_cnt     <= WR_LOAD;
                        last_grant  <= GRANT_WRITE;
                        mem_wen_q   <= (WR_LAT == 1) && wr_ok;
                        state       <= WR_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        // mem_rdata is combinational in the mem_ren cycle.
                        rdata_q  <= acc_ok ? bus.mem_rdata : 32'd0;
                        rresp_q  <= acc_ok ? 2'b00 : 2'b11;
                        rvalid_q <= 1'b1;
                        state    <= RD_RESP;
                    end else begin
                        lat_cnt   <= lat_cnt - 4'd1;
                        mem_ren_q <= (lat_cnt == 4'd1) && acc_ok;
                    end
                end

                RD_RESP: begin
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                WR_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        bresp_q  <= acc_ok ? 2'b00 : 2'b11;
                        bvalid_q <= 1'b1;
                        state    <= WR_RESP;
                    end else begin
                        lat_cnt   <= lat_cnt - 4'd1;
                        mem_wen_q <= (lat_cnt == 4'd1) && acc_ok;
                    end
                end

                WR_RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.arready   = idle & rd_win;
    assign bus.awready   = awready_c;
    assign bus.wready    = wready_c;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.bvalid    = bvalid_q;
    assign bus.bresp     = bresp_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_raddr = mem_raddr_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_pmem_bridge.sv
// +-----------------------------------------------------------------------------+
// | tb_axil_pmem_bridge : directed self-checking bench for axil_pmem_bridge     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_axil_pmem_bridge;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    axil_pmem_bridge_if bus_a ();
    axil_pmem_bridge_if bus_b ();

    axil_pmem_bridge #(.RD_LAT(1), .WR_LAT(3)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    axil_pmem_bridge #(.RD_LAT(4), .WR_LAT(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

`ifdef PMEM_ADDR_CHECK_EN
    localparam logic        EXP_REN   = 1'b0;
    localparam logic        EXP_WEN   = 1'b0;
    localparam logic [1:0]  EXP_RESP  = 2'b11;
    localparam logic [31:0] EXP_RDATA = 32'h0000_0000;
`else
    localparam logic        EXP_REN   = 1'b1;
    localparam logic        EXP_WEN   = 1'b1;
    localparam logic [1:0]  EXP_RESP  = 2'b00;
    localparam logic [31:0] EXP_RDATA = 32'h5A5A_5A5A;
`endif

    // Each cycle starts 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({bus_a.arready, bus_a.awready, bus_a.wready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies_a: got %b expected 000",
                     {bus_a.arready, bus_a.awready, bus_a.wready});
        end
        checks++;
        if ({bus_a.rvalid, bus_a.bvalid, bus_a.mem_ren, bus_a.mem_wen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids_a: got %b expected 0000",
                     {bus_a.rvalid, bus_a.bvalid, bus_a.mem_ren, bus_a.mem_wen});
        end
        checks++;
        if ({bus_a.rdata, bus_a.rresp, bus_a.bresp, bus_a.mem_raddr, bus_a.mem_waddr,
             bus_a.mem_wdata, bus_a.mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_data_a: rdata %h raddr %h waddr %h wdata %h expected all 0",
                     bus_a.rdata, bus_a.mem_raddr, bus_a.mem_waddr, bus_a.mem_wdata);
        end
        checks++;
        if ({bus_b.arready, bus_b.awready, bus_b.wready, bus_b.rvalid, bus_b.mem_ren} !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: got %b expected 00000",
                     {bus_b.arready, bus_b.awready, bus_b.wready, bus_b.rvalid, bus_b.mem_ren});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_a.awready, bus_a.wready} !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 11", {bus_a.awready, bus_a.wready});
        end
        step();
    endtask

    task automatic test_read();
        bus_a.arvalid   = 1'b1;
        bus_a.araddr    = 32'h8000_0000;
        bus_a.mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus_a.arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_arready: got %b expected 1", bus_a.arready);
        end
        step();
        bus_a.arvalid = 1'b0;
        bus_a.araddr  = 32'h0;
        checks++;
        if ({bus_a.mem_ren, bus_a.rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL rd_ren_cycle1: ren,rvalid got %b expected 10", {bus_a.mem_ren, bus_a.rvalid});
        end
        checks++;
        if (bus_a.mem_raddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rd_raddr: got %h expected 80000000", bus_a.mem_raddr);
        end
        step();
        bus_a.mem_rdata = 32'h0;
        #1;
        checks++;
        if ({bus_a.mem_ren, bus_a.rvalid} !== 2'b01) begin
            errors++;
            $display("FAIL rd_rvalid_cycle2: ren,rvalid got %b expected 01", {bus_a.mem_ren, bus_a.rvalid});
        end
        checks++;
        if (bus_a.rdata !== 32'hDEAD_BEEF || bus_a.rresp !== 2'b00) begin
            errors++;
            $display("FAIL rd_data: got %h/%b expected deadbeef/00", bus_a.rdata, bus_a.rresp);
        end
        bus_a.rready = 1'b1;
        step();
        bus_a.rready = 1'b0;
        checks++;
        if (bus_a.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: rvalid got %b expected 0", bus_a.rvalid);
        end
    endtask

    task automatic test_write_w_first();
        bus_a.wvalid = 1'b1;
        bus_a.wdata  = 32'h1234_5678;
        bus_a.wstrb  = 4'b0011;
        #1;
        checks++;
        if (bus_a.wready !== 1'b1) begin
            errors++;
            $display("FAIL wr_wready0: got %b expected 1", bus_a.wready);
        end
        step();
        bus_a.wvalid = 1'b0;
        bus_a.wdata  = 32'h0;
        bus_a.wstrb  = 4'b0;
        #1;
        checks++;
        if ({bus_a.wready, bus_a.awready} !== 2'b01) begin
            errors++;
            $display("FAIL wr_w_held: wready,awready got %b expected 01", {bus_a.wready, bus_a.awready});
        end
        step();
        bus_a.awvalid = 1'b1;
        bus_a.awaddr  = 32'h8000_0010;
        #1;
        checks++;
        if (bus_a.awready !== 1'b1) begin
            errors++;
            $display("FAIL wr_awready2: got %b expected 1", bus_a.awready);
        end
        step();
        bus_a.awvalid = 1'b0;
        bus_a.awaddr  = 32'h0;
        for (int c = 3; c <= 5; c++) begin
            checks++;
            if (bus_a.mem_wen !== (c == 5)) begin
                errors++;
                $display("FAIL wr_wen_cycle%0d: got %b expected %b", c, bus_a.mem_wen, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (bus_a.mem_waddr !== 32'h8000_0010 || bus_a.mem_wdata !== 32'h1234_5678 ||
                    bus_a.mem_wmask !== 4'b0011) begin
                    errors++;
                    $display("FAIL wr_payload: got %h/%h/%b expected 80000010/12345678/0011",
                             bus_a.mem_waddr, bus_a.mem_wdata, bus_a.mem_wmask);
                end
            end
            step();
        end
        checks++;
        if ({bus_a.bvalid, bus_a.bresp, bus_a.mem_wen} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_bvalid6: bvalid,bresp,wen got %b expected 1000",
                     {bus_a.bvalid, bus_a.bresp, bus_a.mem_wen});
        end
        bus_a.bready = 1'b1;
        step();
        bus_a.bready = 1'b0;
        checks++;
        if (bus_a.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: bvalid got %b expected 0", bus_a.bvalid);
        end
    endtask

    task automatic test_arbitration();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        bus_a.arvalid   = 1'b1;
        bus_a.araddr    = 32'h8000_0100;
        bus_a.awvalid   = 1'b1;
        bus_a.awaddr    = 32'h8000_0200;
        bus_a.wvalid    = 1'b1;
        bus_a.wdata     = 32'hA5A5_A5A5;
        bus_a.wstrb     = 4'hF;
        bus_a.mem_rdata = 32'h1111_1111;
        #1;
        checks++;
        if ({bus_a.arready, bus_a.awready, bus_a.wready} !== 3'b100) begin
            errors++;
            $display("FAIL arb_first_read: ar,aw,w ready got %b expected 100",
                     {bus_a.arready, bus_a.awready, bus_a.wready});
        end
        step();
        bus_a.arvalid = 1'b0;
        #1;
        checks++;
        if ({bus_a.mem_ren, bus_a.mem_wen, bus_a.awready, bus_a.wready} !== 4'b1000) begin
            errors++;
            $display("FAIL arb_read_strobe: ren,wen,aw,w got %b expected 1000",
                     {bus_a.mem_ren, bus_a.mem_wen, bus_a.awready, bus_a.wready});
        end
        step();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL arb_read_resp: got %b/%h expected 1/11111111", bus_a.rvalid, bus_a.rdata);
        end
        bus_a.rready = 1'b1;
        step();
        bus_a.rready  = 1'b0;
        bus_a.arvalid = 1'b1;
        bus_a.araddr  = 32'h8000_0300;
        bus_a.mem_rdata = 32'h2222_2222;
        #1;
        checks++;
        if ({bus_a.arready, bus_a.awready, bus_a.wready} !== 3'b011) begin
            errors++;
            $display("FAIL arb_second_write: ar,aw,w ready got %b expected 011",
                     {bus_a.arready, bus_a.awready, bus_a.wready});
        end
        step();
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        #1;
        checks++;
        if (bus_a.arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_busy_arready: got %b expected 0", bus_a.arready);
        end
        step();
        step();
        checks++;
        if ({bus_a.mem_wen, bus_a.mem_ren} !== 2'b10 || bus_a.mem_waddr !== 32'h8000_0200 ||
            bus_a.mem_wdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL arb_write_strobe: wen,ren %b addr %h data %h expected 10/80000200/a5a5a5a5",
                     {bus_a.mem_wen, bus_a.mem_ren}, bus_a.mem_waddr, bus_a.mem_wdata);
        end
        step();
        checks++;
        if (bus_a.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL arb_bvalid: got %b expected 1", bus_a.bvalid);
        end
        bus_a.bready = 1'b1;
        #1;
        checks++;
        if (bus_a.arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_resp_arready: got %b expected 0", bus_a.arready);
        end
        step();
        bus_a.bready = 1'b0;
        #1;
        checks++;
        if (bus_a.arready !== 1'b1) begin
            errors++;
            $display("FAIL arb_third_read: arready got %b expected 1", bus_a.arready);
        end
        step();
        bus_a.arvalid = 1'b0;
        checks++;
        if (bus_a.mem_ren !== 1'b1 || bus_a.mem_raddr !== 32'h8000_0300) begin
            errors++;
            $display("FAIL arb_third_ren: got %b/%h expected 1/80000300", bus_a.mem_ren, bus_a.mem_raddr);
        end
        step();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL arb_third_resp: got %b/%h expected 1/22222222", bus_a.rvalid, bus_a.rdata);
        end
        bus_a.rready = 1'b1;
        step();
        bus_a.rready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus_a.arvalid   = 1'b1;
        bus_a.araddr    = 32'h8000_0400;
        bus_a.mem_rdata = 32'hCAFE_F00D;
        step();
        bus_a.arvalid = 1'b0;
        step();
        bus_a.mem_rdata = 32'h0;
        bus_a.arvalid   = 1'b1;
        bus_a.araddr    = 32'h8000_0500;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'hCAFE_F00D || bus_a.arready !== 1'b0 ||
                bus_a.mem_ren !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: rvalid %b rdata %h arready %b ren %b expected 1/cafef00d/0/0",
                         i, bus_a.rvalid, bus_a.rdata, bus_a.arready, bus_a.mem_ren);
            end
            step();
        end
        bus_a.arvalid = 1'b0;
        bus_a.rready  = 1'b1;
        step();
        bus_a.rready = 1'b0;
        checks++;
        if (bus_a.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rvalid got %b expected 0", bus_a.rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        bus_b.arvalid   = 1'b1;
        bus_b.araddr    = 32'h8000_0600;
        bus_b.mem_rdata = 32'h7777_7777;
        step();
        bus_b.arvalid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_b.mem_ren, bus_b.rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_immediate: ren,rvalid got %b expected 00", {bus_b.mem_ren, bus_b.rvalid});
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus_b.mem_ren, bus_b.rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_quiet%0d: ren,rvalid got %b expected 00", i, {bus_b.mem_ren, bus_b.rvalid});
            end
            step();
        end
        bus_b.arvalid   = 1'b1;
        bus_b.araddr    = 32'h8000_0700;
        bus_b.mem_rdata = 32'h8888_8888;
        #1;
        checks++;
        if (bus_b.arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_arready: got %b expected 1", bus_b.arready);
        end
        step();
        bus_b.arvalid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus_b.mem_ren !== (c == 4)) begin
                errors++;
                $display("FAIL rst_next_ren%0d: got %b expected %b", c, bus_b.mem_ren, (c == 4));
            end
            step();
        end
        checks++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 32'h8888_8888 || bus_b.rresp !== 2'b00) begin
            errors++;
            $display("FAIL rst_next_resp: got %b/%h/%b expected 1/88888888/00",
                     bus_b.rvalid, bus_b.rdata, bus_b.rresp);
        end
        bus_b.rready = 1'b1;
        step();
        bus_b.rready = 1'b0;
    endtask

    task automatic test_addr_check();
        bus_a.arvalid   = 1'b1;
        bus_a.araddr    = 32'h0000_1000;
        bus_a.mem_rdata = 32'h5A5A_5A5A;
        step();
        bus_a.arvalid = 1'b0;
        checks++;
        if (bus_a.mem_ren !== EXP_REN) begin
            errors++;
            $display("FAIL ac_read_ren: got %b expected %b", bus_a.mem_ren, EXP_REN);
        end
`ifndef PMEM_ADDR_CHECK_EN
        checks++;
        if (bus_a.mem_raddr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL ac_read_raddr: got %h expected 00001000", bus_a.mem_raddr);
        end
`endif
        step();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rresp !== EXP_RESP || bus_a.rdata !== EXP_RDATA) begin
            errors++;
            $display("FAIL ac_read_resp: got %b/%b/%h expected 1/%b/%h",
                     bus_a.rvalid, bus_a.rresp, bus_a.rdata, EXP_RESP, EXP_RDATA);
        end
        bus_a.rready = 1'b1;
        step();
        bus_a.rready  = 1'b0;
        bus_a.awvalid = 1'b1;
        bus_a.awaddr  = 32'h9000_0000;
        bus_a.wvalid  = 1'b1;
        bus_a.wdata   = 32'h0BAD_F00D;
        bus_a.wstrb   = 4'b0000;
        #1;
        checks++;
        if ({bus_a.awready, bus_a.wready} !== 2'b11) begin
            errors++;
            $display("FAIL ac_write_ready: got %b expected 11", {bus_a.awready, bus_a.wready});
        end
        step();
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus_a.mem_wen !== ((c == 3) && EXP_WEN)) begin
                errors++;
                $display("FAIL ac_write_wen%0d: got %b expected %b", c, bus_a.mem_wen, ((c == 3) && EXP_WEN));
            end
`ifndef PMEM_ADDR_CHECK_EN
            if (c == 3) begin
                checks++;
                if (bus_a.mem_waddr !== 32'h9000_0000 || bus_a.mem_wmask !== 4'b0000) begin
                    errors++;
                    $display("FAIL ac_write_payload: got %h/%b expected 90000000/0000",
                             bus_a.mem_waddr, bus_a.mem_wmask);
                end
            end
`endif
            step();
        end
        checks++;
        if (bus_a.bvalid !== 1'b1 || bus_a.bresp !== EXP_RESP) begin
            errors++;
            $display("FAIL ac_write_resp: got %b/%b expected 1/%b", bus_a.bvalid, bus_a.bresp, EXP_RESP);
        end
        bus_a.bready = 1'b1;
        step();
        bus_a.bready = 1'b0;
    endtask

    initial begin
        bus_a.arvalid = 1'b0; bus_a.araddr = '0; bus_a.rready = 1'b0;
        bus_a.awvalid = 1'b0; bus_a.awaddr = '0; bus_a.wvalid = 1'b0;
        bus_a.wdata = '0; bus_a.wstrb = '0; bus_a.bready = 1'b0; bus_a.mem_rdata = '0;
        bus_b.arvalid = 1'b0; bus_b.araddr = '0; bus_b.rready = 1'b0;
        bus_b.awvalid = 1'b0; bus_b.awaddr = '0; bus_b.wvalid = 1'b0;
        bus_b.wdata = '0; bus_b.wstrb = '0; bus_b.bready = 1'b0; bus_b.mem_rdata = '0;

        test_reset();
        test_read();
        test_write_w_first();
        test_arbitration();
        test_backpressure();
        test_reset_mid_read();
        test_addr_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
